gate_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 3-input AND/OR gate unit among `NREQ` requesters. Each requester presents a 3-bit operand {p,q,r} and holds a level request. The block grants one requester at a time, latches its operand and drives the shared AND/OR gate chain. It then registers both reduction results and returns a one-cycle acknowledge to the winner. It sits between the requesting control blocks and the gate-unit datapath, and it is the only driver of that datapath's inputs.

---
 rtl/gate_unit_arbiter.sv | 127 ++++++++++++
 tb/tb_gate_unit_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// ---------------------------------------------------------------------------
// gate_unit_arbiter
//
// Round-robin arbiter and sequencer for one shared 3-input AND/OR gate unit.
// A winner is picked among the NREQ level requests. Its operand is latched,
// pushed through the shared AND/OR cascade, and both reductions are
// registered. The winner then gets a one-cycle acknowledge.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   req      in   NREQ     level request, one bit per requester
//   opnd     in   3*NREQ   operand of requester k at opnd[3k+2:3k], {p,q,r}
//   ack      out  NREQ     one-hot, one-cycle completion pulse
//   gnt_id   out  IDW      index of the current or most recent grant
//   and_out  out  1        registered p&q&r of the granted operand
//   or_out   out  1        registered p|q|r of the granted operand
//   busy     out  1        high while in EVAL or ACK
// ---------------------------------------------------------------------------
module gate_unit_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] opnd,
   output logic [NREQ-1:0]   ack,
   output logic [IDW-1:0]    gnt_id,
   output logic              and_out,
   output logic              or_out,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EVAL = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]     state;
   logic [IDW-1:0] ptr;
   logic [2:0]     op_reg;

   // Round-robin winner search
   logic           win_found;
   logic [IDW-1:0] win_id;
   logic [2:0]     win_opnd;

   // The search starts at ptr and wraps modulo NREQ. Only the first hit counts.
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(ptr) + i) % NREQ;
         if (!win_found && req[IDW'(idx)]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
   end

   assign win_opnd = opnd[3*win_id +: 3];

   // Shared gate chain: two 2-input ANDs and two 2-input ORs in cascade
   logic and_stage1, and_stage2;
   logic or_stage1,  or_stage2;

   always_comb begin
      and_stage1 = op_reg[2] & op_reg[1];
      and_stage2 = and_stage1 & op_reg[0];
      or_stage1  = op_reg[2] | op_reg[1];
      or_stage2  = or_stage1 | op_reg[0];
   end

   // Pointer advance
   logic [IDW-1:0] next_ptr;

   always_comb begin
      if (gnt_id == IDW'(NREQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = gnt_id + 1'b1;
      end
   end

   // Sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         op_reg  <= '0;
         gnt_id  <= '0;
         and_out <= 1'b0;
         or_out  <= 1'b0;
         ack     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_reg <= win_opnd;
                  gnt_id <= win_id;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               and_out <= and_stage2;
               or_out  <= or_stage2;
               ack     <= NREQ'(1) << gnt_id;
               state   <= ACK;
            end
            ACK: begin
               ack   <= '0;
               ptr   <= next_ptr;
               state <= IDLE;
            end
            default: begin
               ack   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == EVAL) || (state == ACK);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

   localparam int NREQ = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] opnd;
   logic [NREQ-1:0]   ack;
   logic [1:0]        gnt_id;
   logic              and_out;
   logic              or_out;
   logic              busy;

   int n_chk  = 0;
   int n_pass = 0;

   gate_unit_arbiter #(.NREQ(NREQ)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .opnd    (opnd),
      .ack     (ack),
      .gnt_id  (gnt_id),
      .and_out (and_out),
      .or_out  (or_out),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference model. phase counts the edges since the grant:
   // 0 means waiting for a request, 1 means the result is due, and 2 means
   // the acknowledge is showing.
   int m_phase, m_ptr, m_gnt, m_op, m_and, m_or, m_ack;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_ptr = 0; m_gnt = 0; m_op = 0;
         m_and = 0; m_or = 0; m_ack = 0;
      end else if (m_phase == 0) begin
         if (req != 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
               if (req[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
            end
            m_op    = int'((opnd >> (3 * m_gnt)) & 12'h7);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_and   = (m_op == 7) ? 1 : 0;
         m_or    = (m_op != 0) ? 1 : 0;
         m_ack   = 1 << m_gnt;
         m_phase = 2;
      end else begin
         m_ack   = 0;
         m_ptr   = (m_gnt + 1) % NREQ;
         m_phase = 0;
      end
   end

   // Outputs are registered and always defined, so compare on every falling edge.
   always @(negedge clk) begin
      chk("ack",     int'(ack),     m_ack);
      chk("gnt_id",  int'(gnt_id),  m_gnt);
      chk("and_out", int'(and_out), m_and);
      chk("or_out",  int'(or_out),  m_or);
      chk("busy",    int'(busy),    (m_phase != 0) ? 1 : 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int acks_seen;
   int ack_ids[8];
   int ack_cyc[8];
   logic [2:0] sweep [3];

   initial begin
      rst_n = 1'b0;
      req   = '0;
      opnd  = '0;
      sweep[0] = 3'b000; sweep[1] = 3'b010; sweep[2] = 3'b111;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         req  = 4'($urandom);
         opnd = 12'($urandom);
         tick();
         chk("rst_ack",  int'(ack),  0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_and",  int'(and_out | or_out), 0);
      end
      req = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_busy", int'(busy), 0);
      end

      // Single requester
      req  = 4'b0001;
      opnd = {9'($urandom), 3'b111};
      tick();
      chk("single_busy_eval", int'(busy), 1);
      chk("single_noack",     int'(ack),  0);
      tick();
      chk("single_ack", int'(ack),     1);
      chk("single_and", int'(and_out), 1);
      chk("single_or",  int'(or_out),  1);
      chk("single_id",  int'(gnt_id),  0);
      req = '0;
      tick();
      chk("single_ack_clr", int'(ack),  0);
      chk("single_idle",    int'(busy), 0);

      // Operand sweep on requester 2
      for (int s = 0; s < 3; s++) begin
         req  = 4'b0100;
         opnd = 12'($urandom);
         opnd[8:6] = sweep[s];
         tick();
         tick();
         chk("sweep_ack", int'(ack),     4);
         chk("sweep_id",  int'(gnt_id),  2);
         chk("sweep_and", int'(and_out), (s == 2) ? 1 : 0);
         chk("sweep_or",  int'(or_out),  (s == 0) ? 0 : 1);
         req = '0;
         tick();
      end

      // Pointer wrap: the last grant went to 2, so 3 wins before 0
      req = 4'b1001;
      tick();
      tick();
      chk("wrap_first", int'(ack), 8);
      req = 4'b0001;
      tick();
      tick();
      tick();
      chk("wrap_second", int'(ack), 1);
      req = '0;
      tick();

      // Fairness from reset with every request held
      rst_n = 1'b0;
      req   = 4'b1111;
      tick();
      rst_n = 1'b1;
      acks_seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ack != 0 && acks_seen < 8) begin
            ack_ids[acks_seen] = int'(gnt_id);
            ack_cyc[acks_seen] = i;
            acks_seen++;
         end
      end
      req = '0;
      chk("fair_count", acks_seen, 5);
      for (int j = 0; j < 5 && j < acks_seen; j++) begin
         chk("fair_order", ack_ids[j], j % NREQ);
         chk("fair_cycle", ack_cyc[j], 1 + 3 * j);
      end
      tick();

      // Reset during EVAL aborts the transaction
      req = 4'b1010;
      tick();
      chk("abort_busy_pre", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_id",   int'(gnt_id), 0);
      tick();
      chk("abort_noack", int'(ack), 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("abort_rearb", int'(ack), 2);
      req = '0;
      tick();

      // Operand flip and request drop during EVAL
      req  = 4'b0100;
      opnd = 12'($urandom);
      opnd[8:6] = 3'b110;
      tick();
      opnd = 12'($urandom);
      opnd[8:6] = 3'b001;
      req = '0;
      tick();
      chk("stable_ack", int'(ack),     4);
      chk("stable_and", int'(and_out), 0);
      chk("stable_or",  int'(or_out),  1);
      tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         if ($urandom_range(0, 9) < 3) req = '0;
         else req = 4'($urandom);
         opnd = 12'($urandom);
         tick();
      end
      rst_n = 1'b1;
      req = '0;
      tick();
      tick();
      tick();
      @(negedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
